// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, scheduler state type and the opcode/operand error screen
// shared by the ALU, the scheduler and their users.
package alu_pkg;

    localparam logic [7:0] OP_ADD = 8'd1;
    localparam logic [7:0] OP_SUB = 8'd2;
    localparam logic [7:0] OP_MUL = 8'd3;
    localparam logic [7:0] OP_DIV = 8'd4;
    localparam logic [7:0] OP_AND = 8'd5;
    localparam logic [7:0] OP_OR  = 8'd6;
    localparam logic [7:0] OP_NOT = 8'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // True for an opcode outside 1..7, or a divide whose divisor is zero.
    function automatic logic op_error(input logic [7:0] op, input logic b_zero);
        return (op == 8'd0) || (op > OP_NOT) || ((op == OP_DIV) && b_zero);
    endfunction

endpackage

// File: rtl/alu_sched_if.sv
// alu_sched_if: request/response bundle between N requesters and alu_sched.
//   req_valid/req_ready/req_op/req_a/req_b : per-requester request handshake
//   rsp_valid/rsp_ready                    : per-requester response handshake
//   rsp_data/rsp_err                       : shared result and error flag
// master = requester side, slave = scheduler side.
interface alu_sched_if #(
    parameter int N = 2,
    parameter int W = 8
);
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*8-1:0] req_op;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu.sv
// alu: combinational W-bit ALU.
//   op_i : opcode (alu_pkg OP_*), a_i/b_i : operands, y_o : result.
// Arithmetic wraps modulo 2**W, divide is unsigned floor, NOT ignores b_i.
// Unknown opcodes and divide-by-zero yield zero.
module alu
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [7:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_MUL:  y_o = a_i * b_i;
            OP_DIV:  y_o = (b_i == '0) ? '0 : (a_i / b_i);
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_NOT:  y_o = ~a_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req : request vector, ptr : highest-priority index,
//   gnt : one-hot grant (zero when no request), idx : encoded grant index.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic [N-1:0] rot;
    logic [IW:0]  sum;
    logic         found;

    // Rotate so bit 0 is the requester at ptr, take the lowest set bit, then
    // map the offset back to an absolute index modulo N.
    always_comb begin
        rot   = N'({req, req} >> ptr);
        sum   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (IW+1)'(i);
            end
        end
        if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
        end
        idx = sum[IW-1:0];
        gnt = found ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one ALU among N requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_sched_if slave (requests in, one-hot ready/valid out,
//                shared registered result and error flag)
//   busy       : high whenever an operation is in EXEC or RESP
module alu_sched
    import alu_pkg::*;
#(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_sched_if.slave  bus,
    output logic        busy
);

    localparam int IW = $clog2(N);

    state_e         state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  g_q, g_d;
    logic [7:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   data_q, data_d;
    logic           err_q, err_d;

    logic [N-1:0]   gnt;
    logic [IW-1:0]  gnt_idx;
    logic [W-1:0]   alu_y;
    logic [N-1:0]   req_ready_c;
    logic [N-1:0]   rsp_valid_c;
    logic [7:0]     op_sel;
    logic [W-1:0]   a_sel, b_sel;

    rr_arbiter #(.N(N)) u_arb (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    alu #(.W(W)) u_alu (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .y_o  (alu_y)
    );

    // Operand mux of the winning requester.
    always_comb begin
        op_sel = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt[i]) begin
                op_sel = bus.req_op[i*8 +: 8];
                a_sel  = bus.req_a[i*W +: W];
                b_sel  = bus.req_b[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        g_d         = g_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        data_d      = data_q;
        err_d       = err_q;
        req_ready_c = '0;
        rsp_valid_c = '0;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    req_ready_c = gnt;
                    op_d        = op_sel;
                    a_d         = a_sel;
                    b_d         = b_sel;
                    g_d         = gnt_idx;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                if (op_error(op_q, b_q == '0)) begin
                    data_d = '0;
                    err_d  = 1'b1;
                end else begin
                    data_d = alu_y;
                    err_d  = 1'b0;
                end
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_c = N'(1) << g_q;
                if (bus.rsp_ready[g_q]) begin
                    state_d = IDLE;
                    ptr_d   = (g_q == IW'(N-1)) ? '0 : g_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // The grant path is combinational from req_valid, so it is gated by
    // reset to keep req_ready low while rst_n is asserted.
    assign bus.req_ready = req_ready_c & {N{rst_n}};
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;
    assign busy          = (state_q != IDLE);

endmodule
